// File: rtl/rover_sensor_pkg.sv
// -----------------------------------------------------------------------------
// rover_sensor_pkg
//   Shared definitions for the rover proximity-sensor path. It holds two groups
//   of definitions:
//     - The echo responder: its state encoding, its timing defaults and the
//       echo-width helper.
//     - The proximity-sensor driver: the constants it uses when it issues
//       ranging requests.
//   Both sides import the same numbers, so they cannot drift apart.
// -----------------------------------------------------------------------------
package rover_sensor_pkg;

    // Echo responder states. The encoding is fixed so that debug tooling
    // can decode a state value directly.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG    = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } echo_state_e;

    // Echo responder timing defaults. All of these are in microseconds,
    // except the clock rate and the ranges.
    localparam int ECHO_CLK_PER_US  = 100;    // 100 MHz board clock
    localparam int ECHO_MIN_TRIG_US = 10;
    localparam int ECHO_BURST_US    = 200;
    localparam int ECHO_US_PER_CM   = 58;
    localparam int ECHO_MAX_CM      = 400;
    localparam int ECHO_TIMEOUT_US  = 38000;
    localparam int ECHO_HOLDOFF_US  = 10000;

    // Width of the microsecond counter.
    localparam int US_CNT_W = 16;

    // Proximity-sensor driver constants: the trigger pulse it issues and its
    // measurement period. The period is kept longer than the worst-case echo
    // plus the holdoff.
    localparam int DRV_TRIG_PULSE_US  = 12;
    localparam int DRV_MEAS_PERIOD_US = 60000;
    localparam int DRV_RANGE_W        = 9;

    // Echo width in microseconds for a latched range.
    //   - A distance of 0 reports as 1 cm.
    //   - No object, or a distance beyond max_cm, reports the timeout width.
    //   - The product is formed in 32 bits before it is narrowed. The largest
    //     in-range value is 400*58 = 23200, which fits in 16 bits.
    function automatic logic [US_CNT_W-1:0] echo_width_us(
        input logic [8:0] dist_cm,
        input logic       obst,
        input int         us_per_cm,
        input int         max_cm,
        input int         timeout_us
    );
        int d_eff;
        int prod;
        d_eff = (dist_cm == 9'd0) ? 1 : int'({23'd0, dist_cm});
        prod  = d_eff * us_per_cm;
        if (obst && (int'({23'd0, dist_cm}) <= max_cm)) begin
            return US_CNT_W'(prod);
        end
        return US_CNT_W'(timeout_us);
    endfunction

endpackage

// File: rtl/us_timer.sv
// -----------------------------------------------------------------------------
// us_timer
//   Microsecond timebase for the echo responder. It is made of two counters:
//     - A prescaler that counts 0..CLK_PER_US-1.
//     - A 16-bit microsecond counter that advances each time the prescaler
//       wraps.
//
//   Ports:
//     clk       - system clock, rising edge
//     reset     - synchronous active-high reset; clears both counters
//     clear     - synchronous clear; the owner asserts it on every state entry
//     us_count  - whole microseconds elapsed since the last clear
//                 (saturates at 16'hFFFF)
//     us_tick   - high in the last clock of each microsecond
//                 (prescaler == CLK_PER_US-1)
// -----------------------------------------------------------------------------
module us_timer
    import rover_sensor_pkg::*;
#(
    parameter int CLK_PER_US = ECHO_CLK_PER_US
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    output logic [US_CNT_W-1:0] us_count,
    output logic                us_tick
);

    localparam int          PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);

    logic [PW-1:0]       pre_q, pre_d;
    logic [US_CNT_W-1:0] cnt_q, cnt_d;

    assign us_tick  = (pre_q == PRE_LAST);
    assign us_count = cnt_q;

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (clear) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (us_tick) begin
            pre_d = '0;
            // Saturate so that a trigger held high forever cannot wrap the
            // counter. A wrap would make a long pulse look short.
            if (cnt_q != {US_CNT_W{1'b1}}) begin
                cnt_d = cnt_q + US_CNT_W'(1);
            end
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// -----------------------------------------------------------------------------
// ultrasonic_echo_responder
//   Emulates an HC-SR04 style ultrasonic ranger. The behaviour is:
//     - A trigger pulse of at least MIN_TRIG_US starts a measurement. The
//       range inputs are latched when the trigger falls.
//     - After BURST_US an echo pulse is produced. Its width encodes the
//       latched range.
//     - A HOLDOFF_US dead time follows before the next trigger is accepted.
//
//   Ports:
//     clk          - system clock, rising edge
//     reset        - synchronous active-high reset
//     trigger      - ranging request from the sensor driver
//     distance_cm  - emulated obstacle range in cm (9 bits)
//     obstacle     - 1 = object present, 0 = nothing in range
//     echo         - registered echo pulse
//     busy         - registered, high whenever the FSM is not in IDLE
//     trig_err     - registered one-cycle pulse when a short trigger is
//                    rejected
//
//   Phase lengths are exact clock counts, measured from the state entry:
//     - BURST:   BURST_US*CLK_PER_US cycles
//     - ECHO:    width_us*CLK_PER_US cycles
//     - HOLDOFF: HOLDOFF_US*CLK_PER_US cycles
// -----------------------------------------------------------------------------
module ultrasonic_echo_responder
    import rover_sensor_pkg::*;
#(
    parameter int CLK_PER_US  = ECHO_CLK_PER_US,
    parameter int MIN_TRIG_US = ECHO_MIN_TRIG_US,
    parameter int BURST_US    = ECHO_BURST_US,
    parameter int US_PER_CM   = ECHO_US_PER_CM,
    parameter int MAX_CM      = ECHO_MAX_CM,
    parameter int TIMEOUT_US  = ECHO_TIMEOUT_US,
    parameter int HOLDOFF_US  = ECHO_HOLDOFF_US
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distance_cm,
    input  logic       obstacle,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    localparam logic [US_CNT_W-1:0] MIN_US   = US_CNT_W'(MIN_TRIG_US);
    localparam logic [US_CNT_W-1:0] MIN_M1   = US_CNT_W'(MIN_TRIG_US - 1);
    localparam logic [US_CNT_W-1:0] BURST_M1 = US_CNT_W'(BURST_US - 1);
    localparam logic [US_CNT_W-1:0] HOLD_M1  = US_CNT_W'(HOLDOFF_US - 1);

    echo_state_e state_q, state_d;
    logic        echo_q, echo_d;
    logic        busy_q, busy_d;
    logic        trig_err_q, trig_err_d;
    logic        trig_prev_q, trig_prev_d;
    logic [8:0]  dist_q, dist_d;
    logic        obst_q, obst_d;

    logic [US_CNT_W-1:0] us_count;
    logic                us_tick;
    logic                timer_clear;
    logic [US_CNT_W-1:0] width_us;
    logic [US_CNT_W-1:0] width_m1;
    logic                trig_long;
    logic                burst_done;
    logic                echo_done;
    logic                hold_done;

    us_timer #(
        .CLK_PER_US (CLK_PER_US)
    ) u_us_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .us_count (us_count),
        .us_tick  (us_tick)
    );

    // The width is derived only from the latched range. Input changes made
    // after the trigger falls therefore cannot reshape a pulse in progress.
    assign width_us = echo_width_us(dist_q, obst_q, US_PER_CM, MAX_CM, TIMEOUT_US);
    assign width_m1 = width_us - US_CNT_W'(1);

    // Each phase of D microseconds ends on the last clock of its D-th
    // microsecond, that is when us_count == D-1 and us_tick is high. The
    // state entry cleared the timer, so the phase lasts exactly D*CLK_PER_US
    // cycles.
    assign burst_done = (us_count == BURST_M1) && us_tick;
    assign echo_done  = (us_count == width_m1) && us_tick;
    assign hold_done  = (us_count == HOLD_M1)  && us_tick;

    // Trigger length check. The rising-edge cycle was spent in IDLE, so the
    // number of high cycles is one more than the cycles elapsed in TRIG.
    // The pulse is accepted when (elapsed + 1) >= MIN_TRIG_US*CLK_PER_US.
    assign trig_long = (us_count >= MIN_US) || ((us_count == MIN_M1) && us_tick);

    always_comb begin
        state_d     = state_q;
        echo_d      = 1'b0;
        trig_err_d  = 1'b0;
        dist_d      = dist_q;
        obst_d      = obst_q;
        trig_prev_d = trigger;

        unique case (state_q)
            ST_IDLE: begin
                // Only a true 0->1 edge starts a measurement. A trigger that
                // is already high when IDLE is entered is ignored.
                if (trigger && !trig_prev_q) begin
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (!trigger) begin
                    if (trig_long) begin
                        state_d = ST_BURST;
                        dist_d  = distance_cm;
                        obst_d  = obstacle;
                    end else begin
                        state_d    = ST_IDLE;
                        trig_err_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (burst_done) begin
                    state_d = ST_ECHO;
                    echo_d  = 1'b1;
                end
            end
            ST_ECHO: begin
                if (echo_done) begin
                    state_d = ST_HOLDOFF;
                end else begin
                    echo_d = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (hold_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Restart the timebase on every state change, so that each phase counts
    // from zero.
    assign timer_clear = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            trig_err_q  <= 1'b0;
            // Preset the previous-trigger register high. A trigger held high
            // through reset release then needs a fresh rising edge.
            trig_prev_q <= 1'b1;
            dist_q      <= '0;
            obst_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            trig_err_q  <= trig_err_d;
            trig_prev_q <= trig_prev_d;
            dist_q      <= dist_d;
            obst_q      <= obst_d;
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = trig_err_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// -----------------------------------------------------------------------------
// tb_ultrasonic_echo_responder
//   Directed and randomized bench for ultrasonic_echo_responder. The timing
//   parameters are shrunk so that whole measurements fit in a short run.
//   Expected values come from a small reference model of the ranging rules:
//     - minimum trigger length
//     - burst delay
//     - echo width from the latched range
//     - holdoff time
// -----------------------------------------------------------------------------
module tb_ultrasonic_echo_responder;

    localparam int T_CLK      = 2;
    localparam int T_MIN_TRIG = 5;
    localparam int T_BURST    = 20;
    localparam int T_US_CM    = 3;
    localparam int T_MAX_CM   = 400;
    localparam int T_TIMEOUT  = 1500;
    localparam int T_HOLDOFF  = 30;
    localparam int BOUND      = 10000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic [8:0] distance_cm = '0;
    logic       obstacle = 1'b0;
    logic       echo;
    logic       busy;
    logic       trig_err;

    int n_pass  = 0;
    int n_total = 0;

    ultrasonic_echo_responder #(
        .CLK_PER_US  (T_CLK),
        .MIN_TRIG_US (T_MIN_TRIG),
        .BURST_US    (T_BURST),
        .US_PER_CM   (T_US_CM),
        .MAX_CM      (T_MAX_CM),
        .TIMEOUT_US  (T_TIMEOUT),
        .HOLDOFF_US  (T_HOLDOFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .distance_cm (distance_cm),
        .obstacle    (obstacle),
        .echo        (echo),
        .busy        (busy),
        .trig_err    (trig_err)
    );

    // Clock / timeout
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the ranging rules written as plain arithmetic.
    function automatic int model_width_cycles(input int d, input int o);
        int cm;
        if (o != 0 && d <= T_MAX_CM) begin
            cm = (d < 1) ? 1 : d;
            return cm * T_US_CM * T_CLK;
        end
        return T_TIMEOUT * T_CLK;
    endfunction

    function automatic bit model_accept(input int hi_cycles);
        return hi_cycles >= T_MIN_TRIG * T_CLK;
    endfunction

    // Driver / checker tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full ranging request:
    //   - Drive the trigger high for hi cycles with range d/o, then drop it.
    //   - Check the reject path, or the burst delay, the echo width and the
    //     holdoff length.
    //   - When disturb is set:
    //       - the range inputs are scrambled after the latch;
    //       - the trigger is toggled during burst, echo and holdoff.
    task automatic run_meas(input int hi, input int d, input int o, input bit disturb);
        int  n;
        int  w;
        int  h;
        bit  err_seen;
        bit  echo_early;
        bit  busy_gap;
        err_seen   = 1'b0;
        echo_early = 1'b0;
        busy_gap   = 1'b0;

        trigger = 1'b0;
        cycle();
        distance_cm = 9'(d);
        obstacle    = o[0];
        trigger     = 1'b1;
        for (int i = 0; i < hi; i++) begin
            cycle();
            echo_early |= echo;
            busy_gap   |= ~busy;
            err_seen   |= trig_err;
        end
        check("echo_low_in_trig", 32'(echo_early), 0);
        check("busy_in_trig", 32'(busy_gap), 0);
        trigger = 1'b0;
        cycle();

        if (!model_accept(hi)) begin
            check("trig_err_pulse", 32'(trig_err), 1);
            check("busy_after_reject", 32'(busy), 0);
            cycle();
            check("trig_err_one_cycle", 32'(trig_err), 0);
            echo_early = 1'b0;
            for (int i = 0; i < 2 * T_BURST * T_CLK; i++) begin
                cycle();
                echo_early |= echo | busy;
            end
            check("no_meas_after_reject", 32'(echo_early), 0);
            return;
        end

        check("no_trig_err_on_accept", 32'(trig_err), 0);
        if (disturb) begin
            distance_cm = 9'($urandom_range(0, 511));
            obstacle    = 1'($urandom_range(0, 1));
        end
        n = 1;
        while (!echo && n < BOUND) begin
            if (disturb) trigger = 1'($urandom_range(0, 1));
            cycle();
            n++;
            err_seen |= trig_err;
        end
        check("burst_delay_edges", 32'(n), 32'(T_BURST * T_CLK + 1));

        w = 0;
        while (echo && w < BOUND) begin
            if (disturb) trigger = 1'($urandom_range(0, 1));
            w++;
            cycle();
            err_seen |= trig_err;
        end
        check("echo_width", 32'(w), 32'(model_width_cycles(d, o)));

        h = 0;
        echo_early = 1'b0;
        while (busy && h < BOUND) begin
            if (disturb) trigger = 1'($urandom_range(0, 1));
            h++;
            cycle();
            err_seen   |= trig_err;
            echo_early |= echo;
        end
        trigger = 1'b0;
        check("holdoff_len", 32'(h), 32'(T_HOLDOFF * T_CLK));
        check("echo_low_in_holdoff", 32'(echo_early), 0);
        check("no_trig_err_while_busy", 32'(err_seen), 0);
    endtask

    // Directed sequence
    initial begin
        int  n;
        bit  flag;

        // Reset, with the trigger held high through the release.
        trigger = 1'b1;
        repeat (3) cycle();
        check("reset_echo", 32'(echo), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_trig_err", 32'(trig_err), 0);
        reset = 1'b0;
        flag = 1'b0;
        repeat (20) begin
            cycle();
            flag |= busy;
        end
        check("held_trigger_ignored_after_reset", 32'(flag), 0);

        // Trigger length at, below and far below the minimum.
        run_meas(T_MIN_TRIG * T_CLK - 1, 20, 1, 1'b0);
        run_meas(T_MIN_TRIG * T_CLK, 20, 1, 1'b0);
        run_meas(1, 20, 1, 1'b0);

        // Range corner cases.
        run_meas(15, 0, 1, 1'b0);
        run_meas(15, 400, 1, 1'b0);
        run_meas(15, 401, 1, 1'b0);
        run_meas(15, 450, 1, 1'b0);
        run_meas(12, 20, 0, 1'b0);

        // Long trigger hold, followed by a measurement with disturbed inputs.
        run_meas(300, 0, 1, 1'b1);
        run_meas(12, 100, 1, 1'b1);

        // Randomized measurements.
        for (int k = 0; k < 8; k++) begin
            run_meas(int'($urandom_range(T_MIN_TRIG * T_CLK - 2, T_MIN_TRIG * T_CLK + 30)),
                     int'($urandom_range(0, 460)), int'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)));
        end

        // Reset pulsed mid-ECHO, with the trigger held high through release.
        trigger = 1'b0;
        cycle();
        distance_cm = 9'd400;
        obstacle    = 1'b1;
        trigger     = 1'b1;
        repeat (T_MIN_TRIG * T_CLK + 2) cycle();
        trigger = 1'b0;
        n = 0;
        while (!echo && n < BOUND) begin
            cycle();
            n++;
        end
        repeat (50) cycle();
        check("echo_high_before_reset", 32'(echo), 1);
        reset   = 1'b1;
        trigger = 1'b1;
        cycle();
        check("echo_dropped_by_reset", 32'(echo), 0);
        check("busy_dropped_by_reset", 32'(busy), 0);
        reset = 1'b0;
        flag  = 1'b0;
        repeat (3 * T_BURST * T_CLK) begin
            cycle();
            flag |= echo | busy;
        end
        check("no_residual_after_reset", 32'(flag), 0);

        // A fresh low-then-high trigger gives a normal measurement.
        run_meas(12, 37, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_responder.md
ULTRASONIC_ECHO_RESPONDER -- requirements
Module: ultrasonic_echo_responder

Interface
REQ-001 Parameter CLK_PER_US, 100, clock cycles per microsecond (100 MHz board clock).
REQ-002 Parameter MIN_TRIG_US, 10, minimum trigger high time accepted, us.
REQ-003 Parameter BURST_US, 200, delay from trigger fall to echo rise, us.
REQ-004 Parameter US_PER_CM, 58, echo high time per cm of range, us.
REQ-005 Parameter MAX_CM, 400, largest reportable range, cm.
REQ-006 Parameter TIMEOUT_US, 38000, echo width for no object or out of range, us.
REQ-007 Parameter HOLDOFF_US, 10000, dead time after echo fall before next trigger is accepted, us.
REQ-008 clk  input  1  system clock, all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 trigger  input  1  ranging request from the proximity-sensor driver.
REQ-011 distance_cm  input  9  emulated obstacle range, cm.
REQ-012 obstacle  input  1  1 = object present; 0 = nothing in range.
REQ-013 echo  output  1  echo pulse, width encodes range.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 trig_err  output  1  one-cycle pulse when a too-short trigger is rejected.

Function
REQ-016 Timing SHALL use a microsecond prescaler (0..CLK_PER_US-1) plus a 16-bit microsecond counter; both clear on every state entry.
REQ-017 States SHALL be IDLE, TRIG, BURST, ECHO, HOLDOFF.
REQ-018 IDLE -> TRIG SHALL occur only on a trigger rising edge (trigger=1 with registered previous value 0); a trigger already high on entering IDLE is ignored.
REQ-019 In TRIG, trigger falling after >= MIN_TRIG_US*CLK_PER_US high cycles SHALL go to BURST and latch distance_cm and obstacle in that cycle.
REQ-020 In TRIG, trigger falling earlier SHALL return to IDLE and pulse trig_err for exactly one cycle.
REQ-021 Trigger held high indefinitely SHALL keep the block in TRIG with echo low.
REQ-022 BURST SHALL last BURST_US us, then enter ECHO with echo rising on the transition cycle.
REQ-023 Echo width SHALL be max(latched distance,1)*US_PER_CM us when obstacle=1 and distance <= MAX_CM; otherwise TIMEOUT_US us.
REQ-024 Width product SHALL be computed in at least 16 bits without overflow (400*58 = 23200).
REQ-025 echo SHALL be registered, glitch-free, and high only in ECHO.
REQ-026 ECHO expiry SHALL drop echo and enter HOLDOFF; HOLDOFF expiry SHALL enter IDLE.
REQ-027 trigger activity in BURST, ECHO or HOLDOFF SHALL be ignored; no trig_err.
REQ-028 Changes of distance_cm/obstacle after latching SHALL not affect the pulse in progress.

Reset
REQ-029 reset SHALL force IDLE, echo=0, busy=0, trig_err=0, counters and latched range to 0, previous-trigger register to 1 (a trigger high through reset release needs a new rising edge).
REQ-030 reset asserted mid-ECHO SHALL drop echo on the next rising clk edge; no residual pulse after release.

Structure
REQ-031 State encoding and timing parameter defaults SHALL reside in shared package rover_sensor_pkg, alongside the driver's constants.
REQ-032 The prescaler/us counter SHALL be one sub-module, us_timer (inputs clear, outputs us_count, us_tick).
REQ-033 Parameters SHALL be overridable so benches may shrink CLK_PER_US and HOLDOFF_US.

Verification
REQ-034 Trigger high 1000 cycles, distance 20, obstacle 1 -> echo rises 20000 cycles after trigger fall, high 116000 cycles.
REQ-035 Trigger high 500 cycles -> trig_err one-cycle pulse, echo stays 0, busy 0 next cycle.
REQ-036 obstacle 0 (or distance 450) -> echo high 3800000 cycles.
REQ-037 Distance 0 -> echo high 5800 cycles; distance changed to 300 during BURST -> width unchanged.
REQ-038 Retrigger during ECHO and HOLDOFF -> ignored; first valid trigger after HOLDOFF -> new measurement.
REQ-039 reset pulsed mid-ECHO -> echo 0 next edge; trigger held high through reset release -> no measurement until trigger cycles low then high.
